// File: rtl/accuracy_reporter.sv
// accuracy_reporter: captures the end-of-run correct count, derives the
// percentage and streams "CCCC PPP%\n" over a valid/ready byte port.
module accuracy_reporter #(
    parameter int unsigned TOTAL = 750
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [9:0] accuracy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [6:0] percent,
    output logic       busy,
    output logic       report_done
);
    typedef enum logic [1:0] {IDLE, CONV, BCDP, SEND} state_t;

    localparam logic [16:0] DIVISOR   = 17'(TOTAL);
    localparam logic [4:0]  CONV_LAST = 5'd16;
    localparam logic [4:0]  DD_STEPS  = 5'd10;
    localparam logic [4:0]  BCDP_LAST = 5'd6;
    localparam logic [3:0]  LAST_BYTE = 4'd9;

    state_t      state;
    logic        done_d;
    logic [4:0]  cnt;
    logic [3:0]  idx;
    logic [3:0]  idx_nxt;
    // remainder and dividend; the dividend turns into the quotient
    logic [16:0] rem;
    logic [16:0] dq;
    logic [16:0] shifted;
    logic        fits;
    logic [16:0] rem_next;
    logic [16:0] dq_next;
    logic [6:0]  pct_sat;
    // count BCD digits above the latched count, consumed MSB first
    logic [15:0] cnt_bcd;
    logic [9:0]  acc_r;
    logic [25:0] cnt_step;
    // percent BCD digits above its binary shift register
    logic [18:0] pct_sr;
    logic [18:0] pct_step;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [25:0] dd_cnt(input logic [25:0] v);
        logic [15:0] adj;
        adj = {add3(v[25:22]), add3(v[21:18]),
               add3(v[17:14]), add3(v[13:10])};
        return {adj, v[9:0]} << 1;
    endfunction

    function automatic logic [18:0] dd_pct(input logic [18:0] v);
        logic [11:0] adj;
        adj = {add3(v[18:15]), add3(v[14:11]), add3(v[10:7])};
        return {adj, v[6:0]} << 1;
    endfunction

    function automatic logic [7:0] report_byte(
        input logic [3:0]  i,
        input logic [15:0] c,
        input logic [11:0] p
    );
        logic [7:0] b;
        b = 8'h00;
        unique case (i)
            4'd0:    b = {4'h3, c[15:12]};
            4'd1:    b = {4'h3, c[11:8]};
            4'd2:    b = {4'h3, c[7:4]};
            4'd3:    b = {4'h3, c[3:0]};
            4'd4:    b = 8'h20;
            4'd5:    b = {4'h3, p[11:8]};
            4'd6:    b = {4'h3, p[7:4]};
            4'd7:    b = {4'h3, p[3:0]};
            4'd8:    b = 8'h25;
            4'd9:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // one restoring-division step plus the conversion steps
    always_comb begin
        fits     = {rem, dq[16]} >= {1'b0, DIVISOR};
        shifted  = {rem[15:0], dq[16]};
        rem_next = fits ? shifted - DIVISOR : shifted;
        dq_next  = {dq[15:0], fits};
        pct_sat  = (dq_next > 17'd100) ? 7'd100 : dq_next[6:0];
        cnt_step = dd_cnt({cnt_bcd, acc_r});
        pct_step = dd_pct(pct_sr);
        idx_nxt  = idx + 4'd1;
    end

    // trigger, arithmetic sequencing and the byte stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            done_d      <= 1'b1;
            cnt         <= '0;
            idx         <= '0;
            rem         <= '0;
            dq          <= '0;
            cnt_bcd     <= '0;
            acc_r       <= '0;
            pct_sr      <= '0;
            percent     <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            report_done <= 1'b0;
        end else begin
            done_d      <= done;
            report_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (done && !done_d) begin
                        acc_r   <= accuracy;
                        cnt_bcd <= '0;
                        dq      <= {7'd0, accuracy} * 17'd100;
                        rem     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    rem <= rem_next;
                    dq  <= dq_next;
                    if (cnt < DD_STEPS) begin
                        {cnt_bcd, acc_r} <= cnt_step;
                    end
                    if (cnt == CONV_LAST) begin
                        percent <= pct_sat;
                        pct_sr  <= {12'd0, pct_sat};
                        cnt     <= '0;
                        state   <= BCDP;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                BCDP: begin
                    pct_sr <= pct_step;
                    if (cnt == BCDP_LAST) begin
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= report_byte(4'd0, cnt_bcd,
                                                pct_step[18:7]);
                        state    <= SEND;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (idx == LAST_BYTE) begin
                            idx         <= '0;
                            tx_valid    <= 1'b0;
                            tx_data     <= '0;
                            busy        <= 1'b0;
                            report_done <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            idx     <= idx_nxt;
                            tx_data <= report_byte(idx_nxt, cnt_bcd,
                                                   pct_sr[18:7]);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accuracy_reporter.sv
// tb_accuracy_reporter: directed report, backpressure, retrigger
// and reset scenarios with hand-computed byte strings.
module tb_accuracy_reporter;
    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [9:0] accuracy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [6:0] percent;
    logic       busy;
    logic       report_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    accuracy_reporter #(.TOTAL(750)) dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .accuracy    (accuracy),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .percent     (percent),
        .busy        (busy),
        .report_done (report_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (tx_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic trigger(input logic [9:0] acc);
        accuracy = acc;
        done = 1'b1;
        @(posedge clk);
        #1;
        check("busy_e0", busy, 1);
        done = 1'b0;
    endtask

    task automatic run_report(input logic [9:0] acc, input string exp,
                              input int exp_pct, input int mode,
                              input bit retrig);
        int n;
        int got;
        int cyc;
        int stall;
        bit pulsed;
        logic rdy;
        logic v;
        logic [7:0] d;
        trigger(acc);
        n = 0;
        while (tx_valid !== 1'b1 && n < 100) begin
            done = (retrig && n == 5);
            @(posedge clk);
            #1;
            n++;
        end
        done = 1'b0;
        check("latency", n, 24);
        check("percent", percent, exp_pct);
        got = 0;
        cyc = 0;
        stall = 0;
        pulsed = 0;
        while (got < 10 && cyc < 400) begin
            done = 1'b0;
            if (retrig && got == 2 && !pulsed) begin
                done = 1'b1;
                pulsed = 1;
            end
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (got == 3 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            tx_ready = rdy;
            v = tx_valid;
            d = tx_data;
            @(posedge clk);
            #1;
            cyc++;
            if (v && rdy) begin
                check($sformatf("byte%0d", got), d, exp[got]);
                got++;
            end else if (v) begin
                check("hold", {tx_valid, tx_data}, {1'b1, d});
            end
        end
        done = 1'b0;
        tx_ready = 1'b0;
        check("byte_count", got, 10);
        check("rdone_set", report_done, 1);
        check("busy_end", busy, 0);
        @(posedge clk);
        #1;
        check("rdone_clr", report_done, 0);
        quiet("no_extra", 40);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        done = 1'b0;
        tx_ready = 1'b0;
        accuracy = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rdone", report_done, 0);
        check("rst_pct", percent, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_report(10'd600, "0600 080%\n", 80, 0, 1'b0);
        run_report(10'd749, "0749 099%\n", 99, 0, 1'b0);
        run_report(10'd750, "0750 100%\n", 100, 0, 1'b0);
        run_report(10'd0, "0000 000%\n", 0, 0, 1'b0);
        run_report(10'd1023, "1023 100%\n", 100, 0, 1'b0);
        run_report(10'd345, "0345 046%\n", 46, 1, 1'b0);
        run_report(10'd123, "0123 016%\n", 16, 0, 1'b1);

        rst = 1'b0;
        done = 1'b1;
        accuracy = 10'd500;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        quiet("held_done", 40);
        done = 1'b0;
        @(posedge clk);
        #1;

        trigger(10'd750);
        n = 0;
        while (tx_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_latency", n, 24);
        tx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check("b5_valid", tx_valid, 1);
        check("b5_data", tx_data, 8'h31);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", tx_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tx_ready = 1'b1;
        quiet("after_rst", 40);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/accuracy_reporter.md
# accuracy_reporter

Downstream consumer of the neural processor's end-of-run outputs. On the rising edge of `done` it captures the 10-bit correct-classification count `accuracy`, computes the integer percentage against the number of test samples, and converts both values to ASCII decimal. It then streams a fixed 10-byte report over a valid/ready byte interface, for a UART transmitter or a debug FIFO.

## Interface
- `TOTAL`, default 750: number of test samples in a run (1..1023); the percentage divisor. `TOTAL = 0` is illegal.
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `done` in 1: run-complete level from the neural processor.
- `accuracy` in 10: correct-classification count, valid while `done` is high.
- `tx_data` out 8: report byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts the byte.
- `percent` out 7: last computed percentage, 0..100.
- `busy` out 1: high in every state other than IDLE.
- `report_done` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- The FSM has four states: IDLE, CONV, BCDP and SEND.
- **Trigger:** `done_d` is a registered copy of `done`.
  - Trigger condition: `done & ~done_d`, sampled in IDLE only.
  - `done_d` resets to 1, so a `done` that is held high through reset does not trigger.
  - Rising edges outside IDLE are ignored and are not queued.
- **IDLE:** on trigger, the block latches `accuracy` into `acc_r`, loads the dividend `acc_r*100` (17 bits), and goes to CONV.
- **CONV (17 cycles):**
  - Restoring division: one quotient bit per cycle, MSB first, 17-bit remainder; the result is floor(`acc_r*100/TOTAL`).
  - In parallel, in the first 10 cycles, a double-dabble conversion of `acc_r` produces 4 BCD digits.
  - At exit, `percent` is loaded with min(quotient, 100). The quotient saturates when `accuracy > TOTAL`.
- **BCDP (7 cycles):** double-dabble conversion of the 7-bit `percent` to 3 BCD digits. The block then goes to SEND.
- **SEND:** sends 10 bytes in order:
  - bytes 0-3: count thousands, hundreds, tens, units, each as `0x30 + d`;
  - byte 4: space `0x20`;
  - bytes 5-7: percent hundreds, tens, units;
  - byte 8: `%` `0x25`;
  - byte 9: LF `0x0A`.
  - Leading zeros are always sent.
- **SEND handshake:**
  - A byte transfers on a cycle where `tx_valid & tx_ready`.
  - The byte index is 4 bits and advances only on a transfer.
  - `tx_data` and `tx_valid` are held stable while `tx_valid & ~tx_ready`.
  - `tx_valid` never drops before its transfer completes.
- **End of SEND:** after byte 9 transfers, the FSM goes to IDLE and `report_done` pulses for one cycle.
- **Reset mid-operation:** all state is cleared immediately and the partial report is abandoned. After reset the block sends no further bytes until the next valid trigger.

## Timing
- **Reset values:**
  - `tx_valid` 0, `tx_data` 0x00, `busy` 0, `report_done` 0, `percent` 0;
  - FSM IDLE, `done_d` 1, byte index 0.
- **Let E0 be the clock edge that samples the trigger.**
  - `busy` is high from E0+ (registered).
  - CONV covers edges E1..E17; `percent` is valid after E17.
  - BCDP covers edges E18..E24.
  - `tx_valid` is high with byte 0 after E24.
- **Byte throughput:** one byte per cycle when `tx_ready` is held high. With `tx_ready` constantly high, the last transfer is at edge E34.
- **End of report:** `busy` falls and `report_done` is high in the same cycle, the one after the last transfer. The next trigger can be sampled on the following edge.
- **Combinational paths:** `tx_ready` has no combinational path to any output.
- **Arithmetic:** the dividend is 17 bits (max 102300). The divisor `TOTAL` is zero-extended to 17 bits; the remainder is 17 bits.

## Test plan
- `TOTAL`=750, `accuracy`=600, `done` 0→1, `tx_ready`=1:
  - bytes "0600 080%\n" (30 36 30 30 20 30 38 30 25 0A);
  - `tx_valid` rises 24 cycles after E0;
  - `percent`=80;
  - `report_done` pulses once.
- Boundary values, `TOTAL`=750:
  - `accuracy`=749 → "0749 099%";
  - `accuracy`=750 → "0750 100%";
  - `accuracy`=0 → "0000 000%".
- Saturation: `accuracy`=1023 with `TOTAL`=750 → "1023 100%", `percent`=100.
- Backpressure:
  - `tx_ready` toggles pseudo-randomly, with a 5-cycle stall on byte 3;
  - every byte is delivered exactly once, in order;
  - `tx_data` is stable during each stall.
- Retrigger and reset:
  - a second `done` pulse during CONV and during SEND is ignored, and exactly one report is sent;
  - `done` held high across reset release gives no report;
  - asserting `rst` during byte 5 makes `tx_valid` drop immediately, and nothing more is sent.
